i2s_sample_out: RTL and testbench
=================================

I2S_SAMPLE_OUT -- requirements
Module: i2s_sample_out

Interface
REQ-001 Parameter BCLK_HALF, default 5: clk cycles per sclk half-period; sclk = clk/(2*BCLK_HALF), 3 MHz at 30 MHz clk.
REQ-002 Parameter DEPTH, default 4: sample-pair FIFO depth.
REQ-003 clk  input  1  receive-domain clock; sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 din  input  20  audio sample from frame_dismantle dout.
REQ-006 vin  input  1  din valid; one-cycle strobe per subframe.
REQ-007 channel  input  1  subframe channel tag; 0 = A/left, 1 = B/right.
REQ-008 sclk  output  1  I2S bit clock.
REQ-009 lrclk  output  1  I2S word select; 0 = left, 1 = right.
REQ-010 sdata  output  1  I2S serial data.
REQ-011 fill  output  3  FIFO occupancy in pairs, 0..DEPTH.
REQ-012 overflow  output  1  one-cycle pulse when a pair is dropped.
REQ-013 underflow  output  1  one-cycle pulse when a frame starts with FIFO empty.

Function
REQ-014 Pair assembly, on vin=1 and channel=0: load din into the left holding register and set left_valid; if left_valid is already set, overwrite the held value.
REQ-015 On vin=1 and channel=1 with left_valid=1: push {left, din} (40 bits) into the FIFO the next cycle and clear left_valid.
REQ-016 On vin=1 and channel=1 with left_valid=0: discard din, no push, no flag.
REQ-017 On a push with fill=DEPTH and no same-cycle pop: drop the pair, leave FIFO unchanged, and assert overflow for one cycle.
REQ-018 Push and pop in the same cycle: both take effect and fill is unchanged; a push at fill=DEPTH with a same-cycle pop is accepted.
REQ-019 Divider counts 0..BCLK_HALF-1; at BCLK_HALF-1 it wraps to 0 and sclk toggles.
REQ-020 bit_cnt (6 bits) resets to 63; it advances modulo 64 on each cycle where sclk toggles 1->0 (the falling event).
REQ-021 lrclk, sdata and bit_cnt update only on falling events.
REQ-022 lrclk is 0 for bit_cnt 0..31 and 1 for bit_cnt 32..63.
REQ-023 Pop occurs on the falling event where bit_cnt wraps 63->0.
REQ-024 If fill>0 at that event: load the head pair into the 64-bit output shift register.
REQ-025 If fill=0 at that event: load all zeros and pulse underflow for one cycle.
REQ-026 Slot layout (I2S one-bit delay): bit_cnt 0 carries 0; bits 1..20 carry left[19:0], MSB first; bits 21..32 carry 0; bits 33..52 carry right[19:0], MSB first; bits 53..63 carry 0.
REQ-027 Frame period is 128*BCLK_HALF clk cycles (640 at default), which sets the sample rate to 46.875 kHz.
REQ-028 FIFO pointers wrap modulo DEPTH; FIFO output order is strictly FIFO.
REQ-029 Inputs arriving in any cycle, including a pop cycle, are never lost except by REQ-016 or REQ-017.

Reset
REQ-030 While rst=1, the block SHALL hold sclk=0, lrclk=0, sdata=0, fill=0, overflow=0, underflow=0, divider=0, bit_cnt=63, left_valid=0, FIFO pointers=0 and shift register=0.
REQ-031 rst asserted mid-frame SHALL clear all state immediately (asynchronous) and discard FIFO contents and any held left sample.
REQ-032 After rst deasserts, the first sclk rise SHALL occur BCLK_HALF cycles later, and the first falling event SHALL occur at 2*BCLK_HALF cycles, popping or underflowing as bit_cnt 63->0.

Verification
REQ-033 Reset check: rst pulse -> all outputs 0, fill=0, and first sclk rise exactly 5 clk after release.
REQ-034 Single pair: after the first frame starts, push L=20'hABCDE, R=20'h12345 -> next frame sdata bits 1..20 = ABCDE and 33..52 = 12345, all other bits 0, lrclk low for bits 0..31, fill returns 0.
REQ-035 Starvation: no vin for 3 frames -> underflow pulses exactly once per frame at bit_cnt 0, and sdata stays 0.
REQ-036 Overflow: after the first pop, push 5 pairs back-to-back (L=n, R=n+16, n=1..5) -> fill reaches 4, one overflow pulse on pair 5, and the next 4 frames output pairs 1..4 in order.
REQ-037 Pairing: vin ch=1 (orphan) -> no push; then ch=0 0x11111, ch=0 0x22222, ch=1 0x33333 -> one pair {22222, 33333} is pushed.
REQ-038 Mid-frame reset: assert rst at bit_cnt 40 with fill=2 -> outputs zero immediately, fill=0, and the frame after release outputs zeros with an underflow pulse.

Source files
------------

// File: rtl/i2s_sample_out.sv
// I2S transmitter: pairs left/right subframes, buffers pairs in a small FIFO and
// serialises one pair per 64-bit I2S frame with the standard one-bit data delay.
module i2s_sample_out #(
    parameter int unsigned BCLK_HALF = 5,
    parameter int unsigned DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] din,
    input  logic        vin,
    input  logic        channel,
    output logic        sclk,
    output logic        lrclk,
    output logic        sdata,
    output logic [2:0]  fill,
    output logic        overflow,
    output logic        underflow
);

    localparam int unsigned DivW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(BCLK_HALF - 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [DivW-1:0] div_q, div_d;
    logic            sclk_q, sclk_d;
    logic [5:0]      bit_cnt_q, bit_cnt_d;
    logic            lrclk_q, lrclk_d;
    logic            sdata_q, sdata_d;
    logic [63:0]     shreg_q, shreg_d;
    logic [19:0]     left_q, left_d;
    logic            left_valid_q, left_valid_d;
    logic            push_q, push_d;
    logic [39:0]     pair_q, pair_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;
    logic [39:0]     mem_q [DEPTH];

    logic        tick, fall, frame_wrap, empty, full, pop, push_ok;
    logic [39:0] head;
    logic [63:0] frame_load;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        tick       = (div_q == DivLast);
        fall       = tick & sclk_q;
        frame_wrap = fall & (bit_cnt_q == 6'd63);
        empty      = (cnt_q == '0);
        full       = (cnt_q == CntFull);
        pop        = frame_wrap & ~empty;
        // A pop in the same cycle frees the slot a full FIFO needs for the push.
        push_ok    = push_q & (~full | pop);
        head       = mem_q[rd_ptr_q];
        frame_load = empty ? 64'd0 : {1'b0, head[39:20], 12'd0, head[19:0], 11'd0};

        div_d     = tick ? '0 : div_q + 1'b1;
        sclk_d    = sclk_q ^ tick;
        bit_cnt_d = bit_cnt_q;
        lrclk_d   = lrclk_q;
        sdata_d   = sdata_q;
        shreg_d   = shreg_q;
        if (fall) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            lrclk_d   = bit_cnt_d[5];
            if (frame_wrap) begin
                sdata_d = frame_load[63];
                shreg_d = {frame_load[62:0], 1'b0};
            end else begin
                sdata_d = shreg_q[63];
                shreg_d = {shreg_q[62:0], 1'b0};
            end
        end

        underflow_d = frame_wrap & empty;
        overflow_d  = push_q & ~push_ok;

        left_d       = left_q;
        left_valid_d = left_valid_q;
        push_d       = 1'b0;
        pair_d       = pair_q;
        if (vin) begin
            if (!channel) begin
                left_d       = din;
                left_valid_d = 1'b1;
            end else if (left_valid_q) begin
                push_d       = 1'b1;
                pair_d       = {left_q, din};
                left_valid_d = 1'b0;
            end
        end

        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= '0;
            sclk_q       <= 1'b0;
            bit_cnt_q    <= 6'd63;
            lrclk_q      <= 1'b0;
            sdata_q      <= 1'b0;
            shreg_q      <= '0;
            left_q       <= '0;
            left_valid_q <= 1'b0;
            push_q       <= 1'b0;
            pair_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            div_q        <= div_d;
            sclk_q       <= sclk_d;
            bit_cnt_q    <= bit_cnt_d;
            lrclk_q      <= lrclk_d;
            sdata_q      <= sdata_d;
            shreg_q      <= shreg_d;
            left_q       <= left_d;
            left_valid_q <= left_valid_d;
            push_q       <= push_d;
            pair_q       <= pair_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= pair_q;
        end
    end

    assign sclk      = sclk_q;
    assign lrclk     = lrclk_q;
    assign sdata     = sdata_q;
    assign fill      = 3'(cnt_q);
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_i2s_sample_out.sv
// Bench for i2s_sample_out: directed and random subframes against a queue-based
// model of pairing, FIFO and frame contents; captures frames at sclk rises.
module tb_i2s_sample_out;

    localparam int Depth  = 4;
    localparam int Frame  = 640;
    localparam int First  = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] din = '0;
    logic        vin = 1'b0;
    logic        channel = 1'b0;
    logic        sclk, lrclk, sdata, overflow, underflow;
    logic [2:0]  fill;

    i2s_sample_out #(.BCLK_HALF(5), .DEPTH(Depth)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .vin       (vin),
        .channel   (channel),
        .sclk      (sclk),
        .lrclk     (lrclk),
        .sdata     (sdata),
        .fill      (fill),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Frame capture: rise 0 after reset is the bit_cnt=63 slot, rise m>=1 is bit (m-1)%64.
    logic        sclk_prev;
    int          rise_n;
    logic [63:0] word;
    logic        lr_bad;
    logic [63:0] got_w [64];
    logic        got_lr [64];
    int          got_n, uf_cnt, ov_cnt, uf_bad;

    always @(negedge clk) begin
        if (rst) begin
            sclk_prev <= 1'b0;
            rise_n    <= 0;
            word      <= '0;
            lr_bad    <= 1'b0;
        end else begin
            sclk_prev <= sclk;
            if (underflow) begin
                uf_cnt <= uf_cnt + 1;
                if (cyc < First || (cyc - First) % Frame != 0) uf_bad <= uf_bad + 1;
            end
            if (overflow) ov_cnt <= ov_cnt + 1;
            if (sclk && !sclk_prev) begin
                rise_n <= rise_n + 1;
                if (rise_n >= 1) begin
                    if ((rise_n - 1) % 64 == 63) begin
                        if (got_n < 64) begin
                            got_w[got_n]  <= {word[62:0], sdata};
                            got_lr[got_n] <= !lr_bad && (lrclk === 1'b1);
                        end
                        got_n  <= got_n + 1;
                        word   <= '0;
                        lr_bad <= 1'b0;
                    end else begin
                        word <= {word[62:0], sdata};
                        if (lrclk !== ((rise_n - 1) % 64 >= 32)) lr_bad <= 1'b1;
                    end
                end
            end
        end
    end

    // Reference model
    logic [39:0] mq [$];
    logic [19:0] m_left;
    bit          m_lv;
    int          exp_ov, exp_uf, exp_n, next_pop, rd;
    logic [63:0] exp_w [64];
    int          n_vec, n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_send(input logic ch, input logic [19:0] d);
        if (!ch) begin
            m_left = d;
            m_lv   = 1'b1;
        end else if (m_lv) begin
            if (mq.size() < Depth) mq.push_back({m_left, d});
            else exp_ov++;
            m_lv = 1'b0;
        end
    endtask

    task automatic model_pop();
        logic [39:0] p;
        logic [63:0] w;
        if (mq.size() > 0) begin
            p = mq.pop_front();
            w = {1'b0, p[39:20], 12'd0, p[19:0], 11'd0};
        end else begin
            w = '0;
            exp_uf++;
        end
        if (exp_n < 64) exp_w[exp_n] = w;
        exp_n++;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) begin
            @(negedge clk);
            if (!rst && cyc >= next_pop) begin
                model_pop();
                next_pop += Frame;
            end
        end
    endtask

    task automatic send(input logic ch, input logic [19:0] d);
        vin     = 1'b1;
        channel = ch;
        din     = d;
        model_send(ch, d);
        wait_to(cyc + 1);
        vin = 1'b0;
        wait_to(cyc + 3);
    endtask

    task automatic check_frames();
        for (int i = rd; i < got_n && i < 64; i++) begin
            chk("frame_data", got_w[i], exp_w[i]);
            chk("frame_lrclk", 64'(got_lr[i]), 64'd1);
        end
        rd = got_n;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_sclk"}, 64'(sclk), 64'd0);
        chk({tag, "_lrclk"}, 64'(lrclk), 64'd0);
        chk({tag, "_sdata"}, 64'(sdata), 64'd0);
        chk({tag, "_fill"}, 64'(fill), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_underflow"}, 64'(underflow), 64'd0);
    endtask

    initial begin
        logic [31:0] r;
        int          n;
        // Reset and first sclk rise
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst      = 1'b0;
        next_pop = First;
        wait_to(4);
        chk("sclk_before_rise", 64'(sclk), 64'd0);
        wait_to(5);
        chk("sclk_first_rise", 64'(sclk), 64'd1);

        // Single pair into frame 1
        wait_to(100);
        send(1'b0, 20'hABCDE);
        send(1'b1, 20'h12345);
        wait_to(200);
        chk("single_fill", 64'(fill), 64'(mq.size()));
        wait_to(700);
        chk("single_fill_drained", 64'(fill), 64'(mq.size()));

        // Starvation over frames 2..4
        wait_to(First + 4 * Frame + 100);
        chk("starve_underflows", 64'(uf_cnt), 64'(exp_uf));

        // Overflow: 5 pairs after the frame-5 pop
        wait_to(First + 5 * Frame + 90);
        for (int k = 1; k <= 5; k++) begin
            send(1'b0, 20'(k));
            send(1'b1, 20'(k + 16));
        end
        wait_to(First + 5 * Frame + 190);
        chk("overflow_fill", 64'(fill), 64'(mq.size()));
        chk("overflow_count", 64'(ov_cnt), 64'(exp_ov));

        // Pairing rules, pushed after frame 9 drained the FIFO
        wait_to(First + 9 * Frame + 120);
        chk("pair_fill_empty", 64'(fill), 64'(mq.size()));
        send(1'b1, 20'hAAAAA);
        wait_to(cyc + 4);
        chk("pair_orphan_fill", 64'(fill), 64'(mq.size()));
        send(1'b0, 20'h11111);
        send(1'b0, 20'h22222);
        send(1'b1, 20'h33333);
        wait_to(cyc + 4);
        chk("pair_fill", 64'(fill), 64'(mq.size()));

        // Load three pairs, let frame 11 pop one, reset at bit_cnt 40 with fill=2
        wait_to(First + 10 * Frame + 90);
        for (int k = 0; k < 3; k++) begin
            r = $urandom;
            send(1'b0, r[19:0]);
            r = $urandom;
            send(1'b1, r[19:0]);
        end
        wait_to(First + 10 * Frame + 190);
        chk("pre_reset_fill3", 64'(fill), 64'(mq.size()));
        wait_to(First + 11 * Frame + 400);
        chk("pre_reset_fill2", 64'(fill), 64'(mq.size()));
        chk("pre_reset_lrclk", 64'(lrclk), 64'd1);
        check_frames();
        chk("frames_before_reset", 64'(got_n), 64'd11);
        rst = 1'b1;
        #1;
        check_zero_outputs("midreset");
        mq.delete();
        m_lv = 1'b0;
        exp_n--;  // frame 11 was cut short and never completes
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        next_pop = First;

        // Random subframes over six frames after reset
        for (int f = 0; f < 6; f++) begin
            wait_to(First + f * Frame + 60);
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++) begin
                r = $urandom;
                send(r[31], r[19:0]);
            end
            wait_to(First + f * Frame + 300);
            chk("random_fill", 64'(fill), 64'(mq.size()));
        end
        wait_to(First + 6 * Frame + 20);
        check_frames();
        chk("frames_total", 64'(got_n), 64'd17);
        chk("underflow_total", 64'(uf_cnt), 64'(exp_uf));
        chk("underflow_timing", 64'(uf_bad), 64'd0);
        chk("overflow_total", 64'(ov_cnt), 64'(exp_ov));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
